// File: rtl/core_pkg.sv
// Shared definitions for the single-issue RISC-V core: datapath widths,
// execution controller state encoding and base opcode constants.
package core_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_READ      = 3'd3;
  localparam logic [2:0] ST_EXECUTE   = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_HALT      = 3'd6;

  // RV32I major opcodes (instr[6:0]) consumed by the decoder.
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Sequential next PC; the add wraps naturally at 2^XLEN.
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] cur);
    return cur + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: synchronous active-low reset to RESET_PC and a
// single advance-by-one-instruction enable that wraps modulo 2^32.
module program_counter
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= pc_step(pc);
    end
  end

endmodule

// File: rtl/execution_controller.sv
// Multi-cycle fetch/decode/read/execute/writeback sequencer with PC ownership.
// Optional performance counters are built when EXEC_CTRL_PERF_EN is defined.
module execution_controller
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            fetchReq,
  output logic [XLEN-1:0] fetchAddr,
  input  logic            fetchAck,
  input  logic [XLEN-1:0] fetchData,
  output logic [XLEN-1:0] instr,
  input  logic            isVI,
  input  logic            enRegWrite,
  input  logic            enALU,
  output logic            rfReadEn,
  output logic            aluEn,
  output logic            rfWriteEn,
  output logic [XLEN-1:0] pc,
  output logic            retired,
`ifdef EXEC_CTRL_PERF_EN
  output logic [31:0]     cycleCount,
  output logic [31:0]     retireCount,
`endif
  output logic            busy,
  output logic            illegal
);

  logic [2:0] state;
  logic [2:0] next_state;
  logic       wb_pending;
  logic       ex_pending;

  program_counter #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (state == ST_WRITEBACK),
    .pc      (pc)
  );

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (run) next_state = ST_FETCH;
      ST_FETCH:     if (fetchAck) next_state = ST_DECODE;
      ST_DECODE:    next_state = isVI ? ST_READ : ST_HALT;
      ST_READ:      next_state = ST_EXECUTE;
      ST_EXECUTE:   next_state = ST_WRITEBACK;
      ST_WRITEBACK: next_state = run ? ST_FETCH : ST_IDLE;
      ST_HALT:      next_state = ST_HALT;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      instr      <= '0;
      illegal    <= 1'b0;
      wb_pending <= 1'b0;
      ex_pending <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_FETCH && fetchAck) begin
        instr <= fetchData;
      end
      // Decoder flags are captured once so later stages ignore decoder churn.
      if (state == ST_DECODE) begin
        if (!isVI) begin
          illegal <= 1'b1;
        end else begin
          wb_pending <= enRegWrite;
          ex_pending <= enALU;
        end
      end
    end
  end

  assign fetchReq  = (state == ST_FETCH);
  assign fetchAddr = pc;
  assign rfReadEn  = (state == ST_READ);
  assign aluEn     = (state == ST_EXECUTE) && ex_pending;
  assign rfWriteEn = (state == ST_WRITEBACK) && wb_pending;
  assign retired   = (state == ST_WRITEBACK);
  assign busy      = (state != ST_IDLE) && (state != ST_HALT);

`ifdef EXEC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycleCount  <= '0;
      retireCount <= '0;
    end else begin
      if (busy)    cycleCount  <= cycleCount + 32'd1;
      if (retired) retireCount <= retireCount + 32'd1;
    end
  end
`else
  // Counters and their ports are omitted from this build.
`endif

endmodule

// File: tb/tb_execution_controller.sv
// Directed, table-driven bench for execution_controller; a second instance
// with RESET_PC = 32'hFFFF_FFFC covers PC wrap (and counters under EXEC_CTRL_PERF_EN).
module tb_execution_controller;

  logic        clk = 1'b0;
  logic        rst_n, run, fetchAck, isVI, enRegWrite, enALU;
  logic [31:0] fetchData;

  logic        fetchReq, rfReadEn, aluEn, rfWriteEn, retired, busy, illegal;
  logic [31:0] fetchAddr, instr, pc;
  logic        w_fetchReq, w_rfReadEn, w_aluEn, w_rfWriteEn, w_retired, w_busy, w_illegal;
  logic [31:0] w_fetchAddr, w_instr, w_pc;
`ifdef EXEC_CTRL_PERF_EN
  logic [31:0] cycleCount, retireCount, w_cycleCount, w_retireCount;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;

  typedef struct {
    int          waits;
    logic [31:0] data;
    logic        wr;
    logic        alu;
    logic        drop_run;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  execution_controller dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchAck(fetchAck), .fetchData(fetchData),
    .instr(instr), .isVI(isVI), .enRegWrite(enRegWrite), .enALU(enALU),
    .rfReadEn(rfReadEn), .aluEn(aluEn), .rfWriteEn(rfWriteEn), .pc(pc), .retired(retired),
`ifdef EXEC_CTRL_PERF_EN
    .cycleCount(cycleCount), .retireCount(retireCount),
`endif
    .busy(busy), .illegal(illegal)
  );

  execution_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run),
    .fetchReq(w_fetchReq), .fetchAddr(w_fetchAddr), .fetchAck(fetchAck), .fetchData(fetchData),
    .instr(w_instr), .isVI(isVI), .enRegWrite(enRegWrite), .enALU(enALU),
    .rfReadEn(w_rfReadEn), .aluEn(w_aluEn), .rfWriteEn(w_rfWriteEn), .pc(w_pc), .retired(w_retired),
`ifdef EXEC_CTRL_PERF_EN
    .cycleCount(w_cycleCount), .retireCount(w_retireCount),
`endif
    .busy(w_busy), .illegal(w_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_strobes_low(input string name);
    check(name, {28'd0, fetchReq, rfReadEn, aluEn, rfWriteEn}, 32'd0);
  endtask

  // Entered at a falling edge with the controller in FETCH at exp_pc.
  task automatic run_instr(input vec_t v);
    for (int i = 0; i <= v.waits; i++) begin
      check("fetch_req_held", {31'd0, fetchReq}, 32'd1);
      check("fetch_addr_held", fetchAddr, exp_pc);
      fetchAck  = (i == v.waits);
      fetchData = fetchAck ? v.data : 32'hDEAD_BEEF;
      step();
    end
    fetchAck  = 1'b0;
    fetchData = 32'h0;
    check("decode_instr", instr, v.data);
    check("decode_strobes", {28'd0, fetchReq, rfReadEn, aluEn, rfWriteEn}, 32'd0);
    isVI = 1'b1; enRegWrite = v.wr; enALU = v.alu;
    step();
    // Flip the decoder flags after DECODE; the registered copies must win.
    enRegWrite = ~v.wr; enALU = ~v.alu;
    check("read_strobes", {28'd0, fetchReq, rfReadEn, aluEn, rfWriteEn}, 32'b0100);
    check("read_retired", {31'd0, retired}, 32'd0);
    step();
    check("exec_strobes", {28'd0, fetchReq, rfReadEn, aluEn, rfWriteEn}, {29'd0, v.alu, 1'b0});
    check("exec_instr_stable", instr, v.data);
    if (v.drop_run) run = 1'b0;
    step();
    check("wb_strobes", {28'd0, fetchReq, rfReadEn, aluEn, rfWriteEn}, {31'd0, v.wr});
    check("wb_retired", {31'd0, retired}, 32'd1);
    check("wb_pc_old", pc, exp_pc);
    step();
    exp_pc = exp_pc + 32'd4;
    check("next_pc", pc, exp_pc);
    check("after_wb_retired", {31'd0, retired}, 32'd0);
    check("after_wb_busy", {31'd0, busy}, {31'd0, run});
    check("after_wb_fetch_req", {31'd0, fetchReq}, {31'd0, run});
  endtask

  initial begin
    vecs[0] = '{0, 32'h0020_81B3, 1'b1, 1'b1, 1'b0};   // add x3,x1,x2
    vecs[1] = '{3, 32'h0041_2023, 1'b0, 1'b1, 1'b0};   // sw x4,0(x2)
    vecs[2] = '{1, 32'h0100_00EF, 1'b1, 1'b0, 1'b0};   // jal x1,16
    vecs[3] = '{0, 32'h4020_8233, 1'b1, 1'b1, 1'b1};   // sub x4,x1,x2

    // NOTE: bench inputs are driven with blocking assignments on the falling edge.
    rst_n = 1'b0; run = 1'b0; fetchAck = 1'b0; fetchData = 32'h0;
    isVI = 1'b1; enRegWrite = 1'b0; enALU = 1'b0;
    step(); step();
    check("reset_pc", pc, 32'h0);
    check("reset_instr", instr, 32'h0);
    check_strobes_low("reset_strobes");
    check("reset_status", {29'd0, busy, illegal, retired}, 32'd0);
    check("reset_wrap_pc", w_pc, 32'hFFFF_FFFC);

    rst_n = 1'b1;
    step();
    check("idle_no_run", {30'd0, fetchReq, busy}, 32'd0);
    run = 1'b1;
    step();
    exp_pc = 32'h0;

    for (int i = 0; i < 2; i++) begin
      run_instr(vecs[i]);
      if (i == 0) begin
        check("wrap_pc", w_pc, 32'h0);
`ifdef EXEC_CTRL_PERF_EN
        check("wrap_retire_count", w_retireCount, 32'd1);
        check("wrap_cycle_count", w_cycleCount, 32'd5);
`endif
      end
    end

    // Invalid instruction at pc 8: halt with pc pinned, no retirement.
    check("illegal_fetch_addr", fetchAddr, 32'h8);
    fetchAck = 1'b1; fetchData = 32'h0000_0013;
    step();
    fetchAck = 1'b0; fetchData = 32'h0;
    check("illegal_decode_instr", instr, 32'h0000_0013);
    isVI = 1'b0;
    step();
    check("halt_illegal", {31'd0, illegal}, 32'd1);
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_pc", pc, 32'h8);
    for (int i = 0; i < 20; i++) begin
      fetchAck = i[0]; fetchData = 32'hFFFF_FFFF;
      check("halt_quiet", {26'd0, fetchReq, rfReadEn, aluEn, rfWriteEn, retired, illegal}, 32'd1);
      step();
    end
    check("halt_instr_kept", instr, 32'h0000_0013);
    check("halt_pc_kept", pc, 32'h8);
    fetchAck = 1'b0; fetchData = 32'h0; isVI = 1'b1;

    rst_n = 1'b0;
    step();
    check("reset_clears_illegal", {31'd0, illegal}, 32'd0);
    check("reset_after_halt_pc", pc, 32'h0);
    check("reset_after_halt_instr", instr, 32'h0);
    rst_n = 1'b1;
    step();
    exp_pc = 32'h0;

    // Last vector drops run during EXECUTE and must still retire.
    for (int i = 2; i < 4; i++) run_instr(vecs[i]);
    for (int i = 0; i < 5; i++) begin
      check("idle_after_drop", {30'd0, fetchReq, busy}, 32'd0);
      step();
    end
    check("idle_pc", pc, 32'h8);

    // Reset while a fetch is outstanding.
    run = 1'b1;
    step();
    check("midfetch_req", {31'd0, fetchReq}, 32'd1);
    check("midfetch_instr", instr, vecs[3].data);
    rst_n = 1'b0;
    step();
    check("midfetch_reset_pc", pc, 32'h0);
    check("midfetch_reset_addr", fetchAddr, 32'h0);
    check("midfetch_reset_instr", instr, 32'h0);
    check_strobes_low("midfetch_reset_strobes");
    check("midfetch_reset_status", {29'd0, busy, illegal, retired}, 32'd0);
`ifdef EXEC_CTRL_PERF_EN
    check("midfetch_reset_counts", cycleCount | retireCount, 32'd0);
`endif
    rst_n = 1'b1; run = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
